// File: rtl/bus_router_pkg.sv
// ----------------------------------------------------------------------------
// configure : shared configuration for the memory-bus router.
//   slave_count    : number of slave regions in the default map
//   timeout_cycles : default wait-cycle limit before a hung slave is aborted
//   addr_map_t     : one region, inclusive base / exclusive top
//   base_addr/top_addr : default map (iram, dram, uart, clint, plic)
//   router_state_t : router FSM states
//   in_region()    : unsigned region membership test
// ----------------------------------------------------------------------------
package configure;

   localparam int unsigned slave_count    = 5;
   localparam int unsigned timeout_cycles = 255;

   typedef struct packed {
      logic [31:0] base;
      logic [31:0] top;
   } addr_map_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      MISS = 2'd2
   } router_state_t;

   //                                          iram          dram          uart          clint         plic
   localparam logic [31:0] base_addr [slave_count] = '{32'h0000_0000, 32'h0004_0000, 32'h0100_0000, 32'h0200_0000, 32'h0C00_0000};
   localparam logic [31:0] top_addr  [slave_count] = '{32'h0004_0000, 32'h0008_0000, 32'h0100_1000, 32'h0201_0000, 32'h1000_0000};

   function automatic logic in_region(input addr_map_t region, input logic [31:0] addr);
      return (addr >= region.base) && (addr < region.top);
   endfunction

endpackage

// File: rtl/bus_router_decoder.sv
// ----------------------------------------------------------------------------
// bus_decoder : combinational address decoder with first-match priority.
//   m_addr : byte address to decode
//   hit    : address falls inside at least one region
//   index  : lowest-numbered matching region (0 when no hit)
// ----------------------------------------------------------------------------
module bus_decoder #(
   parameter int unsigned slave_count = configure::slave_count,
   parameter logic [31:0] base_addr [slave_count] = configure::base_addr,
   parameter logic [31:0] top_addr  [slave_count] = configure::top_addr,
   localparam int unsigned idx_w = (slave_count > 1) ? $clog2(slave_count) : 1
)(
   input  logic [31:0]      m_addr,
   output logic             hit,
   output logic [idx_w-1:0] index
);
   import configure::*;

   logic [slave_count-1:0] region_hit_s;

   // Per-region membership flags.
   always_comb begin
      region_hit_s = '0;
      for (int i = 0; i < int'(slave_count); i++) begin
         region_hit_s[i] = in_region(addr_map_t'{base: base_addr[i], top: top_addr[i]}, m_addr);
      end
   end

   // Scan from the highest index down so the lowest matching index is the one left standing.
   always_comb begin
      hit   = |region_hit_s;
      index = '0;
      for (int i = int'(slave_count) - 1; i >= 0; i--) begin
         index = region_hit_s[i] ? idx_w'(i) : index;
      end
   end

endmodule

// File: rtl/bus_router.sv
// ----------------------------------------------------------------------------
// bus_router : routes the core's single memory port to one of slave_count
// slaves, one outstanding transaction at a time.
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   m_valid/m_instr/m_addr/m_wdata/m_wstrb : request from the core
//   m_ready/m_rdata/m_error : one-cycle response to the core
//   s_valid                 : one-hot request pulse to the selected slave
//   s_instr/s_addr/s_wdata/s_wstrb : broadcast copies of the request fields
//   s_ready/s_rdata         : per-slave response pulse and read data
// Unmapped addresses get an error response one cycle later; a slave that does
// not answer within timeout_cycles is aborted with an error response.
// ----------------------------------------------------------------------------
module bus_router #(
   parameter int unsigned slave_count    = configure::slave_count,
   parameter logic [31:0] base_addr [slave_count] = configure::base_addr,
   parameter logic [31:0] top_addr  [slave_count] = configure::top_addr,
   parameter int unsigned timeout_cycles = configure::timeout_cycles
)(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     m_valid,
   input  logic                     m_instr,
   input  logic [31:0]              m_addr,
   input  logic [31:0]              m_wdata,
   input  logic [3:0]               m_wstrb,
   output logic                     m_ready,
   output logic [31:0]              m_rdata,
   output logic                     m_error,
   output logic [slave_count-1:0]   s_valid,
   output logic                     s_instr,
   output logic [31:0]              s_addr,
   output logic [31:0]              s_wdata,
   output logic [3:0]               s_wstrb,
   input  logic [slave_count-1:0]   s_ready,
   input  logic [32*slave_count-1:0] s_rdata
);
   import configure::*;

   localparam int unsigned idx_w     = (slave_count > 1) ? $clog2(slave_count) : 1;
   // cnt holds the number of BUSY cycles already spent without a ready.
   localparam logic [15:0] cnt_limit = 16'(timeout_cycles - 1);

   router_state_t    state_q, state_d;
   logic [idx_w-1:0] sel_q, sel_d;
   logic [15:0]      cnt_q, cnt_d;

   logic             dec_hit_s;
   logic [idx_w-1:0] dec_index_s;
   logic             new_ready_s;
   logic             sel_ready_s;
   logic             timed_out_s;

   bus_decoder #(
      .slave_count (slave_count),
      .base_addr   (base_addr),
      .top_addr    (top_addr)
   ) u_decoder (
      .m_addr (m_addr),
      .hit    (dec_hit_s),
      .index  (dec_index_s)
   );

   assign s_instr     = m_instr;
   assign s_addr      = m_addr;
   assign s_wdata     = m_wdata;
   assign s_wstrb     = m_wstrb;

   assign new_ready_s = s_ready[dec_index_s];
   assign sel_ready_s = s_ready[sel_q];
   assign timed_out_s = (cnt_q == cnt_limit);

   // State, selected slave and wait counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sel_q   <= '0;
         cnt_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; requests outside IDLE are protocol violations and dropped.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (m_valid && dec_hit_s) begin
               sel_d   = dec_index_s;
               cnt_d   = 16'h0000;
               // A zero-wait slave completes in the request cycle.
               state_d = new_ready_s ? IDLE : BUSY;
            end else if (m_valid) begin
               state_d = MISS;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (sel_ready_s || timed_out_s) begin
               state_d = IDLE;
            end else begin
               state_d = BUSY;
               cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'h0001;
            end
         end
         MISS: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Response and slave-request outputs; held quiet while reset is asserted.
   always_comb begin
      m_ready = 1'b0;
      m_error = 1'b0;
      m_rdata = 32'h0000_0000;
      s_valid = '0;
      if (reset) begin
         case (state_q)
            IDLE: begin
               if (m_valid && dec_hit_s) begin
                  s_valid = (slave_count)'(1'b1) << dec_index_s;
                  m_ready = new_ready_s;
                  m_rdata = new_ready_s ? s_rdata[32*dec_index_s +: 32] : 32'h0000_0000;
               end else begin
                  s_valid = '0;
               end
            end
            BUSY: begin
               if (sel_ready_s) begin
                  m_ready = 1'b1;
                  m_rdata = s_rdata[32*sel_q +: 32];
               end else if (timed_out_s) begin
                  m_ready = 1'b1;
                  m_error = 1'b1;
               end else begin
                  m_ready = 1'b0;
               end
            end
            MISS: begin
               m_ready = 1'b1;
               m_error = 1'b1;
            end
            default: begin
               m_ready = 1'b0;
            end
         endcase
      end else begin
         m_ready = 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_router.sv
// ----------------------------------------------------------------------------
// tb_bus_router : randomized self-checking bench for bus_router.
// The reference model works per transaction: from the address map it finds
// the target slave, and from the slave latency and the timeout it derives the
// response cycle, data and error flag, then checks every cycle against that.
// ----------------------------------------------------------------------------
module tb_bus_router;
   import configure::*;

   localparam int unsigned T  = 8;
   localparam int unsigned NS = configure::slave_count;

   // Deliberately overlapping map for the priority checks.
   localparam logic [31:0] ovl_base [3] = '{32'h0000_0100, 32'h0000_0000, 32'h0000_0100};
   localparam logic [31:0] ovl_top  [3] = '{32'h0000_0200, 32'h0000_1000, 32'h0000_0180};

   logic              clock = 1'b0;
   logic              reset;
   logic              m_valid, m_instr;
   logic [31:0]       m_addr, m_wdata;
   logic [3:0]        m_wstrb;
   logic              m_ready, m_error;
   logic [31:0]       m_rdata;
   logic [NS-1:0]     s_valid, s_ready;
   logic              s_instr;
   logic [31:0]       s_addr, s_wdata;
   logic [3:0]        s_wstrb;
   logic [32*NS-1:0]  s_rdata;

   logic              o_ready, o_error, o_s_instr;
   logic [31:0]       o_rdata, o_s_addr, o_s_wdata;
   logic [3:0]        o_s_wstrb;
   logic [2:0]        o_s_valid;
   logic [2:0]        o_s_ready = 3'b111;
   logic [95:0]       o_s_rdata = 96'h0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   bus_router #(.timeout_cycles(T)) u_dut (
      .clock(clock), .reset(reset),
      .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(m_ready), .m_rdata(m_rdata), .m_error(m_error),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata)
   );

   bus_router #(.slave_count(3), .base_addr(ovl_base), .top_addr(ovl_top), .timeout_cycles(T)) u_ovl (
      .clock(clock), .reset(reset),
      .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(o_ready), .m_rdata(o_rdata), .m_error(o_error),
      .s_valid(o_s_valid), .s_instr(o_s_instr), .s_addr(o_s_addr), .s_wdata(o_s_wdata), .s_wstrb(o_s_wstrb),
      .s_ready(o_s_ready), .s_rdata(o_s_rdata)
   );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Which slave owns an address: the first region in map order, -1 if none.
   function automatic int ref_slave(input logic [31:0] a);
      for (int i = 0; i < int'(NS); i++) begin
         if (a >= base_addr[i] && a < top_addr[i]) return i;
      end
      return -1;
   endfunction

   task automatic randomize_rdata();
      for (int i = 0; i < int'(NS); i++) s_rdata[32*i +: 32] = $urandom();
   endtask

   // One transaction starting at posedge+1; returns at posedge+1 after its last cycle.
   task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input int lat, input string tag);
      int k, resp, last;
      bit err;
      logic [NS-1:0] exp_sv;
      k = ref_slave(addr);
      if (k < 0) begin
         resp = 1; err = 1'b1; last = 1;
      end else begin
         resp = (lat <= int'(T)) ? lat : int'(T);
         err  = (lat > int'(T));
         last = (lat > resp) ? lat : resp;
      end
      for (int c = 0; c <= last; c++) begin
         m_instr = 1'($urandom());
         m_wdata = $urandom();
         m_wstrb = (c == 0) ? wstrb : 4'($urandom());
         if (c == 0) begin
            m_valid = 1'b1; m_addr = addr;
         end else if (c <= resp && $urandom_range(0, 3) == 0) begin
            m_valid = 1'b1; m_addr = $urandom();   // violation: must be dropped
         end else begin
            m_valid = 1'b0; m_addr = $urandom();
         end
         s_ready = NS'($urandom());
         if (k >= 0) s_ready[k] = (c == lat);
         randomize_rdata();
         #3;
         exp_sv = '0;
         if (c == 0 && k >= 0) exp_sv[k] = 1'b1;
         check_eq({tag, ".s_valid"}, s_valid, exp_sv);
         check_eq({tag, ".m_ready"}, m_ready, (c == resp));
         check_eq({tag, ".m_error"}, m_error, (c == resp) && err);
         check_eq({tag, ".m_rdata"}, m_rdata,
                  (c == resp && !err) ? s_rdata[32*k +: 32] : 32'h0);
         if (c == 0)
            check_eq({tag, ".mirror"}, {s_instr, s_addr, s_wdata, s_wstrb},
                     {m_instr, m_addr, m_wdata, m_wstrb});
         @(posedge clock); #1;
      end
      m_valid = 1'b0;
      s_ready = '0;
   endtask

   logic [31:0] ovl_addr [4] = '{32'h150, 32'h50, 32'h1F0, 32'h170};
   logic [2:0]  ovl_exp  [4] = '{3'b001, 3'b010, 3'b001, 3'b001};

   initial begin
      int r, lat;
      logic [31:0] a;

      // Reset with an active hit request: everything must stay quiet.
      reset = 1'b0; m_valid = 1'b1; m_instr = 1'b0; m_addr = 32'h0004_0010;
      m_wdata = 32'h0; m_wstrb = 4'h0; s_ready = '1; randomize_rdata();
      #12;
      check_eq("rst.m_ready", m_ready, 1'b0);
      check_eq("rst.m_error", m_error, 1'b0);
      check_eq("rst.m_rdata", m_rdata, 32'h0);
      check_eq("rst.s_valid", s_valid, '0);
      @(posedge clock); #1;
      reset = 1'b1; m_valid = 1'b0; s_ready = '0;
      @(posedge clock); #1;

      // Directed cases.
      run_txn(32'h0004_0010, 4'h0, 3, "dram_rd");
      run_txn(32'h0100_0000, 4'b0001, 0, "uart_wr");
      run_txn(32'h9000_0000, 4'h0, 0, "unmapped");
      run_txn(32'h0200_0000, 4'h0, 9, "clint_to");
      run_txn(32'h0003_FFFF, 4'h0, 1, "iram_top");
      run_txn(32'h0004_0000, 4'h0, 1, "dram_base");
      run_txn(32'h0008_0000, 4'h0, 0, "gap");
      run_txn(32'h0007_FFFC, 4'hF, T, "edge_ready");

      // Overlapping map: lowest index wins.
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
         m_valid = 1'b1; m_addr = ovl_addr[i]; m_wdata = $urandom(); m_wstrb = 4'($urandom());
         s_ready = '0; s_ready[0] = 1'b1;    // main map: iram, zero wait
         #3;
         check_eq("ovl.s_valid", o_s_valid, ovl_exp[i]);
         check_eq("ovl.resp", {o_ready, o_error, o_rdata}, {1'b1, 1'b0, 32'h0});
         check_eq("ovl.mirror", {o_s_instr, o_s_addr, o_s_wdata, o_s_wstrb},
                  {m_instr, m_addr, m_wdata, m_wstrb});
         check_eq("ovl.main_s_valid", s_valid, NS'(1));
         @(posedge clock); #1;
      end
      m_valid = 1'b0; s_ready = '0;
      @(posedge clock); #1;

      // Reset asserted while BUSY: no response, then a clean transaction.
      m_valid = 1'b1; m_addr = 32'h0000_0020; s_ready = '0;
      @(posedge clock); #1;
      m_valid = 1'b0;
      @(posedge clock); #1;
      #2; reset = 1'b0; s_ready[0] = 1'b1;
      #1;
      check_eq("busy_rst.m_ready", m_ready, 1'b0);
      @(posedge clock); #1;
      reset = 1'b1;
      #3;
      check_eq("busy_rst.stray", m_ready, 1'b0);
      @(posedge clock); #1;
      s_ready = '0;
      run_txn(32'h0000_0100, 4'h0, 2, "post_rst");

      // Randomized traffic, back to back.
      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, NS);
         if (r == int'(NS)) a = 32'h0008_0000 + $urandom_range(0, 32'h00F7_FFFF);
         else a = base_addr[r] + $urandom_range(0, top_addr[r] - base_addr[r] - 1);
         lat = $urandom_range(0, T + 2);
         run_txn(a, 4'($urandom()), lat, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
